rs232_tx_arbiter: RTL and testbench

- Shares one rs232out serial transmitter among NREQ byte producers, e.g. CPU console, debug monitor and boot loader.
- Arbitrates round-robin into a small byte FIFO and drains the FIFO into the transmitter's transmit_data/we/busy interface with correct busy-latency handling.
- Optional line locking keeps one requester's text line contiguous on the serial output.

---
 rtl/rs232_tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin byte arbiter and FIFO feeding one rs232out transmitter
//
// Shares a single serial transmitter among NREQ byte producers. Bytes are
// accepted one per cycle into a 2^FIFO_LOG2 FIFO and drained into the
// transmitter's transmit_data/we/busy interface. With LOCK_ON_NEWLINE set,
// a requester keeps the grant until it sends 8'h0A, so text lines stay whole.
//
// Ports:
//   clock       - single clock, all state on posedge
//   reset_n     - asynchronous active-low reset
//   req_valid   - per-requester byte offer
//   req_data    - requester i byte in [8i+7:8i]
//   req_ready   - combinational grant; transfer when valid & ready
//   tx_data     - registered byte to transmitter
//   tx_we       - registered one-cycle write strobe to transmitter
//   tx_busy     - transmitter busy
//   fifo_level  - current FIFO occupancy
//   idle        - FIFO empty, drain FSM idle and transmitter not busy
module rs232_tx_arbiter #(
   parameter int NREQ            = 2,
   parameter int FIFO_LOG2       = 4,
   parameter int LOCK_ON_NEWLINE = 1,
   parameter int LOCK_TIMEOUT    = 4096
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [8*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_we,
   input  logic                 tx_busy,
   output logic [FIFO_LOG2:0]   fifo_level,
   output logic                 idle
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int LW    = FIFO_LOG2 + 1;
   localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW    = $clog2(LOCK_TIMEOUT);

   localparam logic [FIFO_LOG2-1:0] PTR_INC    = FIFO_LOG2'(1);
   localparam logic [LW-1:0]        LVL_INC    = LW'(1);
   localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
   localparam logic [TW-1:0]        CNT_INC    = TW'(1);
   localparam logic [TW-1:0]        CNT_MAX    = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_GUARD} drain_state_t;

   logic [7:0]           mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [LW-1:0]        count;
   logic                 full;

   logic [IW-1:0]        last_grant;
   logic [IW-1:0]        lock_owner;
   logic                 locked;
   logic [TW-1:0]        lock_cnt;

   logic                 win_found;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        acc_idx;
   logic [7:0]           acc_data;
   logic                 accept;
   logic                 pop;

   drain_state_t         state;
   drain_state_t         state_nx;
   logic                 tx_we_nx;
   logic [7:0]           tx_data_nx;

   assign full = (count == FULL_LEVEL);

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      logic [IW-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last_grant) + k) % NREQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // A full FIFO blocks everyone; a held lock restricts the grant to its owner.
   always_comb begin
      req_ready = '0;
      if (!full) begin
         if (locked) begin
            req_ready[lock_owner] = req_valid[lock_owner];
         end else if (win_found) begin
            req_ready[win_idx] = 1'b1;
         end
      end
   end

   assign acc_idx = locked ? lock_owner : win_idx;
   assign accept  = |(req_valid & req_ready);

   always_comb begin
      acc_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (acc_idx == IW'(i)) begin
            acc_data = req_data[8*i +: 8];
         end
      end
   end

   // FIFO storage needs no reset; the pointers and level define validity.
   always_ff @(posedge clock) begin
      if (accept) begin
         mem[wr_ptr] <= acc_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_INC;
         end
         case ({accept, pop})
            2'b10:   count <= count + LVL_INC;
            2'b01:   count <= count - LVL_INC;
            default: count <= count;
         endcase
      end
   end

   // Arbitration history, line lock and the lock-owner idle timeout.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= '0;
         lock_owner <= '0;
         locked     <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         if (accept) begin
            last_grant <= acc_idx;
         end
         if (locked) begin
            if (accept) begin
               lock_cnt <= '0;
            end else if (full && req_valid[lock_owner]) begin
               // Owner is stalled by back-pressure, not idle: hold the count.
               lock_cnt <= lock_cnt;
            end else if (lock_cnt == CNT_MAX) begin
               locked   <= 1'b0;
               lock_cnt <= '0;
            end else begin
               lock_cnt <= lock_cnt + CNT_INC;
            end
         end
         if (accept && (LOCK_ON_NEWLINE != 0)) begin
            locked     <= (acc_data != 8'h0A);
            lock_owner <= acc_idx;
         end
      end
   end

   // Drain FSM. GUARD skips one cycle because the transmitter only raises
   // busy the cycle after it sees we, so busy is not yet meaningful there.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         tx_we   <= 1'b0;
         tx_data <= '0;
      end else begin
         state   <= state_nx;
         tx_we   <= tx_we_nx;
         tx_data <= tx_data_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      tx_we_nx   = 1'b0;
      tx_data_nx = tx_data;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if ((count != '0) && !tx_busy) begin
               pop        = 1'b1;
               tx_we_nx   = 1'b1;
               tx_data_nx = mem[rd_ptr];
               state_nx   = S_GUARD;
            end
         end
         S_GUARD: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign fifo_level = count;
   assign idle       = (count == '0) && (state == S_IDLE) && !tx_busy;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb/tb_rs232_tx_arbiter.sv - scoreboard testbench for rs232_tx_arbiter
module tb_rs232_tx_arbiter;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;

   logic [1:0]  req_valid = '0;
   logic [15:0] req_data  = '0;
   logic [1:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_we;
   logic        tx_busy;
   logic [2:0]  fifo_level;
   logic        idle;

   logic [1:0]  rr_valid = '0;
   logic [15:0] rr_data  = '0;
   logic [1:0]  rr_ready;
   logic [7:0]  rr_tx_data;
   logic        rr_tx_we;
   logic        rr_busy;
   logic [2:0]  rr_level;
   logic        rr_idle;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic force_busy  = 1'b0;
   int   busy_len    = 3;
   int   bcnt        = 0;
   int   rr_busy_len = 20;
   int   rr_bcnt     = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rr_exp_q[$];
   int         we_q[$];
   int         rr_we_cnt = 0;

   logic [7:0] src_mem [4][16];
   int         src_len [4];
   int         src_idx [4];
   int         src_start [4];
   int         acc_edge [4][16];
   logic [3:0] last_fire;
   logic [1:0] last_ready;
   int         blocked;

   logic m_prev_we = 1'b0, m_prev_busy = 1'b0;
   logic r_prev_we = 1'b0, r_prev_busy = 1'b0;

   assign tx_busy = force_busy | (bcnt != 0);
   assign rr_busy = (rr_bcnt != 0);

   rs232_tx_arbiter #(
      .NREQ(2), .FIFO_LOG2(2), .LOCK_ON_NEWLINE(1), .LOCK_TIMEOUT(8)
   ) u_dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
      .fifo_level(fifo_level), .idle(idle)
   );

   rs232_tx_arbiter #(
      .NREQ(2), .FIFO_LOG2(2), .LOCK_ON_NEWLINE(0), .LOCK_TIMEOUT(4096)
   ) u_rr (
      .clock(clock), .reset_n(reset_n),
      .req_valid(rr_valid), .req_data(rr_data), .req_ready(rr_ready),
      .tx_data(rr_tx_data), .tx_we(rr_tx_we), .tx_busy(rr_busy),
      .fifo_level(rr_level), .idle(rr_idle)
   );

   initial forever #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cyc <= cyc + 1;
   end

   // Transmitter models: busy rises the cycle after we and lasts busy_len cycles.
   initial forever begin
      @(posedge clock);
      if (tx_we && busy_len != 0) bcnt <= busy_len;
      else if (bcnt != 0)         bcnt <= bcnt - 1;
   end

   initial forever begin
      @(posedge clock);
      if (rr_tx_we && rr_busy_len != 0) rr_bcnt <= rr_busy_len;
      else if (rr_bcnt != 0)            rr_bcnt <= rr_bcnt - 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitors: pop the scoreboard on every tx_we and check the strobe shape.
   initial forever begin
      @(negedge clock);
      if (reset_n && tx_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_data: got %02h expected nothing", tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               errors++;
               $display("FAIL tx_data: got %02h expected %02h", tx_data, e);
            end
         end
         we_q.push_back(cyc);
         checks++;
         if (m_prev_we || m_prev_busy) begin
            errors++;
            $display("FAIL tx_we_shape: prev_we=%0b prev_busy=%0b expected 0 0", m_prev_we, m_prev_busy);
         end
      end
      m_prev_we   = tx_we;
      m_prev_busy = tx_busy;
   end

   initial forever begin
      @(negedge clock);
      if (reset_n && rr_tx_we) begin
         checks++;
         if (rr_exp_q.size() == 0) begin
            errors++;
            $display("FAIL rr_tx_data: got %02h expected nothing", rr_tx_data);
         end else begin
            logic [7:0] e;
            e = rr_exp_q.pop_front();
            if (rr_tx_data !== e) begin
               errors++;
               $display("FAIL rr_tx_data: got %02h expected %02h", rr_tx_data, e);
            end
         end
         rr_we_cnt++;
         checks++;
         if (r_prev_we || r_prev_busy) begin
            errors++;
            $display("FAIL rr_tx_we_shape: prev_we=%0b prev_busy=%0b expected 0 0", r_prev_we, r_prev_busy);
         end
      end
      r_prev_we   = rr_tx_we;
      r_prev_busy = rr_busy;
   end

   // One clock of stimulus: drive sources, sample handshakes at negedge,
   // advance sources that transferred after the edge.
   task automatic step();
      logic [3:0] v;
      for (int s = 0; s < 4; s++) begin
         v[s] = (cyc >= src_start[s]) && (src_idx[s] < src_len[s]);
      end
      req_valid = v[1:0];
      req_data  = {src_mem[1][src_idx[1]], src_mem[0][src_idx[0]]};
      rr_valid  = v[3:2];
      rr_data   = {src_mem[3][src_idx[3]], src_mem[2][src_idx[2]]};
      @(negedge clock);
      chk("ready_onehot", int'($onehot0(req_ready)), 1);
      last_ready = req_ready;
      last_fire  = {rr_valid & rr_ready, req_valid & req_ready};
      for (int s = 0; s < 4; s++) begin
         if (last_fire[s]) acc_edge[s][src_idx[s]] = cyc + 1;
      end
      @(posedge clock);
      #1;
      for (int s = 0; s < 4; s++) begin
         if (last_fire[s]) src_idx[s]++;
      end
   endtask

   task automatic load(input int s, input int n, input int start, input logic [63:0] bytes);
      for (int k = 0; k < n; k++) src_mem[s][k] = bytes[8*k +: 8];
      src_len[s]   = n;
      src_idx[s]   = 0;
      src_start[s] = start;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      force_busy = 1'b0;
      for (int s = 0; s < 4; s++) begin
         src_len[s]   = 0;
         src_idx[s]   = 0;
         src_start[s] = 0;
         for (int k = 0; k < 16; k++) begin
            src_mem[s][k]  = '0;
            acc_edge[s][k] = -100;
         end
      end
      req_valid = '0;
      rr_valid  = '0;
      we_q.delete();
      rr_we_cnt = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 800; i++) begin
         if (exp_q.size() == 0 && rr_exp_q.size() == 0 && idle && rr_idle) break;
         step();
      end
      chk(name, exp_q.size() + rr_exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Reset state and single byte
      chk("rst_tx_we", int'(tx_we), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_idle", int'(idle), 1);
      chk("rst_rr_level", int'(rr_level), 0);
      busy_len = 3;
      load(0, 1, 0, 64'h41);
      exp_q.push_back(8'h41);
      step();
      chk("t1_ready", int'(last_fire[1:0]), 1);
      chk("t1_level", int'(fifo_level), 1);
      wait_drain("t1_drain");
      chk("t1_we_count", we_q.size(), 1);
      if (we_q.size() == 1) chk("t1_latency", we_q[0] - acc_edge[0][0], 1);
      chk("t1_level_end", int'(fifo_level), 0);

      // Line lock: "hi\n" from req0, req1 must wait for the newline
      do_reset();
      load(0, 3, 0, 64'h0A_69_68);
      load(1, 2, 1 << 30, 64'h42_41);
      exp_q.push_back(8'h68); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42);
      for (int i = 0; i < 20 && src_idx[0] < 1; i++) step();
      src_start[1] = 0;
      blocked = 0;
      for (int i = 0; i < 100 && src_idx[0] < 3; i++) begin
         step();
         if (last_ready[1]) blocked++;
      end
      chk("t2_r1_blocked", blocked, 0);
      for (int i = 0; i < 20 && src_idx[1] < 1; i++) step();
      chk("t2_handover", acc_edge[1][0] - acc_edge[0][2], 1);
      wait_drain("t2_drain");

      // Lock timeout: owner goes silent after "x", req1 granted after 8 idle cycles
      do_reset();
      load(0, 1, 0, 64'h78);
      load(1, 1, 1 << 30, 64'h79);
      exp_q.push_back(8'h78); exp_q.push_back(8'h79);
      for (int i = 0; i < 20 && src_idx[0] < 1; i++) step();
      src_start[1] = 0;
      for (int i = 0; i < 50 && src_idx[1] < 1; i++) step();
      chk("t3_timeout_grant", acc_edge[1][0] - acc_edge[0][0], 9);
      wait_drain("t3_drain");

      // FIFO full with busy held, then drain at 2-cycle spacing
      do_reset();
      busy_len   = 0;
      force_busy = 1'b1;
      load(0, 6, 0, 64'h15_14_13_12_11_10);
      for (int k = 0; k < 6; k++) exp_q.push_back(8'h10 + 8'(k));
      repeat (8) step();
      chk("t4_accepts", src_idx[0], 4);
      chk("t4_level", int'(fifo_level), 4);
      chk("t4_ready_full", int'(last_ready), 0);
      chk("t4_not_idle", int'(idle), 0);
      force_busy = 1'b0;
      wait_drain("t4_drain");
      chk("t4_we_count", we_q.size(), 6);
      for (int i = 1; i < we_q.size(); i++) chk("t4_spacing", we_q[i] - we_q[i-1], 2);

      // Reset mid-operation: 3 bytes queued and tx_we high
      do_reset();
      busy_len   = 0;
      force_busy = 1'b1;
      load(0, 4, 0, 64'h24_23_22_21);
      exp_q.push_back(8'h21);
      repeat (6) step();
      chk("t5_level_full", int'(fifo_level), 4);
      force_busy = 1'b0;
      step();
      chk("t5_we_before", int'(tx_we), 1);
      chk("t5_level_before", int'(fifo_level), 3);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_we", int'(tx_we), 0);
      chk("t5_rst_level", int'(fifo_level), 0);
      chk("t5_rst_data", int'(tx_data), 0);
      src_len[0] = 0;
      req_valid  = '0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (30) step();
      chk("t5_no_stale", we_q.size(), 1);
      chk("t5_queue_empty", exp_q.size(), 0);
      chk("t5_idle", int'(idle), 1);

      // Pure round-robin with a slow transmitter
      do_reset();
      load(2, 4, cyc, 64'hA3_A2_A1_A0);
      load(3, 4, cyc + 1, 64'hB3_B2_B1_B0);
      for (int k = 0; k < 4; k++) begin
         rr_exp_q.push_back(8'hA0 + 8'(k));
         rr_exp_q.push_back(8'hB0 + 8'(k));
      end
      wait_drain("rr_drain");
      chk("rr_we_count", rr_we_cnt, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
